// File: rtl/frame_layer_sequencer.sv
// Frame sequencer: per-tick update pulse, then painter's-order layer draw requests.
// Optional scrolling of one layer's y origin under FRAME_LAYER_SEQUENCER_SCROLL_EN.
module frame_layer_sequencer #(
    parameter int CLOCK_FREQ    = 50000000,
    parameter int FRAME_RATE    = 10,
    parameter int NUM_LAYERS    = 4,
    parameter int ID_WIDTH      = 4,
    parameter int UPDATE_CYCLES = 21
`ifdef FRAME_LAYER_SEQUENCER_SCROLL_EN
    ,
    parameter int SCROLL_LAYER  = 1,
    parameter int SCROLL_STEP   = 4,
    parameter int SCROLL_MIN    = 68,
    parameter int SCROLL_MAX    = 100
`endif
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic [NUM_LAYERS-1:0]          layer_en,
    input  logic [8*NUM_LAYERS-1:0]        layer_x,
    input  logic [9*NUM_LAYERS-1:0]        layer_y,
    input  logic [ID_WIDTH*NUM_LAYERS-1:0] layer_id,
    input  logic                           ready,
    output logic                           draw,
    output logic [7:0]                     x_origin,
    output logic [8:0]                     y_origin,
    output logic [ID_WIDTH-1:0]            rom_id,
    output logic                           update_req,
    output logic [2:0]                     layer_idx,
    output logic                           busy,
    output logic                           frame_done,
    output logic                           overrun
);

    localparam int DIV     = CLOCK_FREQ / FRAME_RATE;
    localparam int DIV_W   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int PULSE_W = (UPDATE_CYCLES > 1) ? $clog2(UPDATE_CYCLES) : 1;

    localparam logic [DIV_W-1:0]   DIV_LAST   = DIV_W'(DIV - 1);
    localparam logic [PULSE_W-1:0] PULSE_LAST = PULSE_W'(UPDATE_CYCLES - 1);
    localparam logic [2:0]         LAST_LAYER = 3'(NUM_LAYERS - 1);

    // state  | meaning
    // IDLE   | waiting for the frame tick
    // UPDATE | update_req pulse for UPDATE_CYCLES cycles
    // SELECT | test layer_idx enable, latch layer or skip
    // REQ    | draw asserted until the engine drops ready
    // WAIT   | engine drawing, wait for ready to return
    // DONE   | one-cycle frame_done
    typedef enum logic [2:0] {
        IDLE,
        UPDATE,
        SELECT,
        REQ,
        WAIT,
        DONE
    } state_t;

    state_t               state;
    state_t               state_nxt;
    logic [DIV_W-1:0]     div_cnt;
    logic                 tick;
    logic [PULSE_W-1:0]   pulse_cnt;
    logic [PULSE_W-1:0]   pulse_nxt;
    logic [2:0]           idx_nxt;
    logic                 load_layer;
    logic                 last_layer;

    logic                 sel_en;
    logic [7:0]           sel_x;
    logic [8:0]           sel_y;
    logic [ID_WIDTH-1:0]  sel_id;
    logic [8:0]           y_load;

    // Frame divider runs freely from reset release; tick is its terminal count.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            div_cnt <= '0;
        end else if (div_cnt == DIV_LAST) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    assign tick       = (div_cnt == DIV_LAST);
    assign last_layer = (layer_idx == LAST_LAYER);
    assign busy       = (state != IDLE);

    always_comb begin
        sel_en = 1'b0;
        sel_x  = '0;
        sel_y  = '0;
        sel_id = '0;
        for (int i = 0; i < NUM_LAYERS; i++) begin
            if (layer_idx == 3'(i)) begin
                sel_en = layer_en[i];
                sel_x  = layer_x[8*i +: 8];
                sel_y  = layer_y[9*i +: 9];
                sel_id = layer_id[ID_WIDTH*i +: ID_WIDTH];
            end
        end
    end

`ifdef FRAME_LAYER_SEQUENCER_SCROLL_EN
    localparam logic [8:0] SCROLL_MAX_V  = 9'(SCROLL_MAX);
    localparam logic [8:0] SCROLL_MIN_V  = 9'(SCROLL_MIN);
    localparam logic [8:0] SCROLL_STEP_V = 9'(SCROLL_STEP);
    localparam logic [2:0] SCROLL_IDX    = 3'(SCROLL_LAYER);

    logic [8:0] scroll_off;

    // Offset steps once per completed draw of the scroll layer, wrapping at the floor.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            scroll_off <= SCROLL_MAX_V;
        end else if (state == WAIT && ready && layer_idx == SCROLL_IDX) begin
            if (scroll_off <= SCROLL_MIN_V) begin
                scroll_off <= SCROLL_MAX_V;
            end else begin
                scroll_off <= scroll_off - SCROLL_STEP_V;
            end
        end
    end

    assign y_load = (layer_idx == SCROLL_IDX) ? scroll_off : sel_y;
`else
    assign y_load = sel_y;
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        idx_nxt    = layer_idx;
        pulse_nxt  = pulse_cnt;
        load_layer = 1'b0;
        draw       = 1'b0;
        update_req = 1'b0;
        frame_done = 1'b0;
        case (state)
            IDLE: begin
                if (tick) begin
                    state_nxt = UPDATE;
                    pulse_nxt = '0;
                    idx_nxt   = '0;
                end
            end
            UPDATE: begin
                update_req = 1'b1;
                if (pulse_cnt == PULSE_LAST) begin
                    state_nxt = SELECT;
                    idx_nxt   = '0;
                end else begin
                    pulse_nxt = pulse_cnt + 1'b1;
                end
            end
            SELECT: begin
                if (sel_en) begin
                    load_layer = 1'b1;
                    state_nxt  = REQ;
                end else if (last_layer) begin
                    state_nxt = DONE;
                end else begin
                    idx_nxt = layer_idx + 3'd1;
                end
            end
            REQ: begin
                // draw follows ready combinationally so it drops in the accept cycle
                if (ready) begin
                    draw = 1'b1;
                end else begin
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (ready) begin
                    if (last_layer) begin
                        state_nxt = DONE;
                    end else begin
                        idx_nxt   = layer_idx + 3'd1;
                        state_nxt = SELECT;
                    end
                end
            end
            DONE: begin
                frame_done = 1'b1;
                state_nxt  = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            layer_idx <= '0;
            pulse_cnt <= '0;
            x_origin  <= '0;
            y_origin  <= '0;
            rom_id    <= '0;
            overrun   <= 1'b0;
        end else begin
            layer_idx <= idx_nxt;
            pulse_cnt <= pulse_nxt;
            if (load_layer) begin
                x_origin <= sel_x;
                y_origin <= y_load;
                rom_id   <= sel_id;
            end
            if (tick && state != IDLE) begin
                overrun <= 1'b1;
            end
        end
    end

endmodule
